// File: rtl/dev_bus_arbiter_pkg.sv
// Shared definitions for the two-master device bus arbiter:
// transfer phase encoding, master indices and the default lock bound.
package dev_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int LOCK_MAX_DEFAULT = 4;

endpackage

// File: rtl/rr_arb2.sv
// Combinational winner select between two masters: a lock hit keeps the
// previous owner, a lone request wins outright, a tie goes to the other master.
module rr_arb2
   import dev_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       lock_hit,
   output logic       win
);

   always_comb begin
      win = M0;
      if (lock_hit) begin
         win = last;
      end else if (req == 2'b10) begin
         win = M1;
      end else if (req == 2'b11) begin
         win = ~last;
      end
   end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Shares the device bus between the CPU data port (M0) and the DMA engine (M1).
// Each transfer runs IDLE -> ACCESS -> RESP with round-robin and bounded lock.
module dev_bus_arbiter
   import dev_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wd,
   input  logic              m0_we,
   output logic              m0_gnt,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rd,
   input  logic              m1_req,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wd,
   input  logic              m1_we,
   output logic              m1_gnt,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rd,
   output logic [ADDR_W-1:0] dev_addr,
   output logic [DATA_W-1:0] dev_wd,
   output logic              dev_we,
   input  logic [DATA_W-1:0] dev_rd
);

   localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

   arb_state_t state;
   logic       sel;
   logic       last;
   logic       lock_flag;
   logic [3:0] lock_cnt;
   logic [1:0] req;
   logic       lock_hit;
   logic       win;

   assign req = {m1_req, m0_req};

   // Lock only matters under contention; a lone requester always restarts the count.
   assign lock_hit = lock_flag && (lock_cnt < LOCK_LIM) && (req == 2'b11);

   rr_arb2 u_rr_arb2 (
      .req      (req),
      .last     (last),
      .lock_hit (lock_hit),
      .win      (win)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         sel       <= M0;
         last      <= M1;
         lock_flag <= 1'b0;
         lock_cnt  <= 4'd0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rd     <= '0;
         m1_rd     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  sel      <= win;
                  m0_gnt   <= (win == M0);
                  m1_gnt   <= (win == M1);
                  lock_cnt <= lock_hit ? lock_cnt + 4'd1 : 4'd1;
                  state    <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (sel == M1) begin
                  m1_rd <= dev_rd;
               end else begin
                  m0_rd <= dev_rd;
               end
               m0_ack <= (sel == M0);
               m1_ack <= (sel == M1);
               state  <= ST_RESP;
            end
            ST_RESP: begin
               m0_ack    <= 1'b0;
               m1_ack    <= 1'b0;
               m0_gnt    <= 1'b0;
               m1_gnt    <= 1'b0;
               last      <= sel;
               lock_flag <= (sel == M1) ? m1_lock : m0_lock;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // The device bus is live only during ACCESS, so an async reset silences it at once.
   always_comb begin
      dev_addr = '0;
      dev_wd   = '0;
      dev_we   = 1'b0;
      if (state == ST_ACCESS) begin
         if (sel == M1) begin
            dev_addr = m1_addr;
            dev_wd   = m1_wd;
            dev_we   = m1_we;
         end else begin
            dev_addr = m0_addr;
            dev_wd   = m0_wd;
            dev_we   = m0_we;
         end
      end
   end

endmodule
